// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port to L2 between NUM_REQ L1
// controllers; one single-beat read or write in flight, granted lane passed through.
module l2_port_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int NUM_REQ          = 2
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,

    input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [NUM_REQ-1:0]                    s_axi_awvalid,
    output logic [NUM_REQ-1:0]                    s_axi_awready,
    input  logic [NUM_REQ*C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [NUM_REQ-1:0]                    s_axi_wvalid,
    output logic [NUM_REQ-1:0]                    s_axi_wready,
    output logic [NUM_REQ*2-1:0]                  s_axi_bresp,
    output logic [NUM_REQ-1:0]                    s_axi_bvalid,
    input  logic [NUM_REQ-1:0]                    s_axi_bready,
    input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [NUM_REQ-1:0]                    s_axi_arvalid,
    output logic [NUM_REQ-1:0]                    s_axi_arready,
    output logic [NUM_REQ*C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [NUM_REQ*2-1:0]                  s_axi_rresp,
    output logic [NUM_REQ-1:0]                    s_axi_rvalid,
    input  logic [NUM_REQ-1:0]                    s_axi_rready,

    output logic [C_AXI_ADDR_WIDTH-1:0]           m_axi_awaddr,
    output logic                                  m_axi_awvalid,
    input  logic                                  m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]           m_axi_wdata,
    output logic                                  m_axi_wvalid,
    input  logic                                  m_axi_wready,
    input  logic [1:0]                            m_axi_bresp,
    input  logic                                  m_axi_bvalid,
    output logic                                  m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic                                  m_axi_arvalid,
    input  logic                                  m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rvalid,
    output logic                                  m_axi_rready,

    output logic [NUM_REQ-1:0]                    grant,
    output logic                                  busy
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int N  = NUM_REQ;
    localparam int IW = $clog2(NUM_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR_AW = 3'd1;
    localparam logic [2:0] S_WR_W  = 3'd2;
    localparam logic [2:0] S_WR_B  = 3'd3;
    localparam logic [2:0] S_RD_AR = 3'd4;
    localparam logic [2:0] S_RD_R  = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] rr_ptr;
    logic [N-1:0]  grant_q;

    logic [N-1:0]  req;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [IW:0]   idx_sum;

    assign req = s_axi_awvalid | s_axi_arvalid;

    // Scan from furthest to nearest so the first requester after rr_ptr is the last
    // assignment and therefore the winner.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        idx_sum   = '0;
        for (int k = N; k >= 1; k--) begin
            idx_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx_sum >= (IW+1)'(N))
                idx_sum = idx_sum - (IW+1)'(N);
            if (req[idx_sum[IW-1:0]]) begin
                win_idx   = idx_sum[IW-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // Write beats read for the same requester; its read re-arbitrates later.
                if (win_found)
                    state_nxt = s_axi_awvalid[win_idx] ? S_WR_AW : S_RD_AR;
            end
            S_WR_AW: if (m_axi_awvalid && m_axi_awready) state_nxt = S_WR_W;
            S_WR_W:  if (m_axi_wvalid && m_axi_wready)   state_nxt = S_WR_B;
            S_WR_B:  if (m_axi_bvalid && m_axi_bready)   state_nxt = S_IDLE;
            S_RD_AR: if (m_axi_arvalid && m_axi_arready) state_nxt = S_RD_R;
            S_RD_R:  if (m_axi_rvalid && m_axi_rready)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: reset is asynchronous so every valid/ready output, all decoded from state,
    // drops the moment aresetn falls, even mid-transaction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            gnt_idx <= '0;
            grant_q <= '0;
            rr_ptr  <= IW'(N-1);
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && win_found) begin
                gnt_idx <= win_idx;
                grant_q <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            end else if (state != S_IDLE && state_nxt == S_IDLE) begin
                rr_ptr  <= gnt_idx;
                grant_q <= '0;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bvalid  = '0;
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        m_axi_awaddr  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            S_WR_AW: begin
                m_axi_awaddr           = s_axi_awaddr[gnt_idx*AW +: AW];
                m_axi_awvalid          = s_axi_awvalid[gnt_idx];
                s_axi_awready[gnt_idx] = m_axi_awready;
            end
            S_WR_W: begin
                m_axi_wdata           = s_axi_wdata[gnt_idx*DW +: DW];
                m_axi_wvalid          = s_axi_wvalid[gnt_idx];
                s_axi_wready[gnt_idx] = m_axi_wready;
            end
            S_WR_B: begin
                s_axi_bvalid[gnt_idx] = m_axi_bvalid;
                m_axi_bready          = s_axi_bready[gnt_idx];
            end
            S_RD_AR: begin
                m_axi_araddr           = s_axi_araddr[gnt_idx*AW +: AW];
                m_axi_arvalid          = s_axi_arvalid[gnt_idx];
                s_axi_arready[gnt_idx] = m_axi_arready;
            end
            S_RD_R: begin
                s_axi_rvalid[gnt_idx] = m_axi_rvalid;
                m_axi_rready          = s_axi_rready[gnt_idx];
            end
            default: ;
        endcase
    end

    // Response payloads are broadcast; only the valids are steered to the owner.
    assign s_axi_rdata = {N{m_axi_rdata}};
    assign s_axi_rresp = {N{m_axi_rresp}};
    assign s_axi_bresp = {N{m_axi_bresp}};

    assign grant = grant_q;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter (NUM_REQ=2): the L2 side is driven by hand,
// cycle by cycle, and each comparison is an immediate assertion.
module tb_l2_port_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    logic [63:0] s_axi_awaddr;
    logic [1:0]  s_axi_awvalid;
    logic [1:0]  s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [1:0]  s_axi_wvalid;
    logic [1:0]  s_axi_wready;
    logic [3:0]  s_axi_bresp;
    logic [1:0]  s_axi_bvalid;
    logic [1:0]  s_axi_bready;
    logic [63:0] s_axi_araddr;
    logic [1:0]  s_axi_arvalid;
    logic [1:0]  s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [3:0]  s_axi_rresp;
    logic [1:0]  s_axi_rvalid;
    logic [1:0]  s_axi_rready;

    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    logic [1:0]  grant;
    logic        busy;

    logic [17:0] all_vr;
    int          tests = 0;
    int          failed = 0;

    assign all_vr = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                     grant, busy};

    l2_port_arbiter #(
        .C_AXI_ADDR_WIDTH(32),
        .C_AXI_DATA_WIDTH(32),
        .NUM_REQ(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .grant(grant), .busy(busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        s_axi_awaddr = '0; s_axi_awvalid = '0; s_axi_wdata = '0; s_axi_wvalid = '0;
        s_axi_bready = '0; s_axi_araddr = '0; s_axi_arvalid = '0; s_axi_rready = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
    endtask

    // Entered one cycle into RD_AR for lane; finishes back in IDLE.
    task automatic read_txn(input int lane, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] resp);
        logic [1:0] onehot;
        onehot = 2'b01 << lane;
        #1;
        check("rd_grant", grant, onehot);
        check("rd_busy", busy, 1);
        check("rd_m_arvalid", m_axi_arvalid, 1);
        check("rd_m_araddr", m_axi_araddr, addr);
        check("rd_s_arready_low", s_axi_arready, 0);
        m_axi_arready = 1'b1;
        #1;
        check("rd_s_arready", s_axi_arready, onehot);
        tick();
        s_axi_arvalid[lane] = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata = data;
        m_axi_rresp = resp;
        s_axi_rready[lane] = 1'b1;
        #1;
        check("rd_s_rvalid", s_axi_rvalid, onehot);
        check("rd_s_rdata", s_axi_rdata[lane*32 +: 32], data);
        check("rd_s_rresp", s_axi_rresp[lane*2 +: 2], resp);
        check("rd_m_rready", m_axi_rready, 1);
        check("rd_m_araddr_idle", m_axi_araddr, 0);
        tick();
        m_axi_rvalid = 1'b0;
        s_axi_rready = '0;
        #1;
        check("rd_done_grant", grant, 0);
        check("rd_done_busy", busy, 0);
    endtask

    // Entered one cycle into WR_AW for lane; finishes back in IDLE.
    task automatic write_txn(input int lane, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input int aw_stall, input int w_stall);
        logic [1:0] onehot;
        onehot = 2'b01 << lane;
        #1;
        check("wr_grant", grant, onehot);
        check("wr_m_awvalid", m_axi_awvalid, 1);
        check("wr_m_awaddr", m_axi_awaddr, addr);
        check("wr_m_wvalid_early", m_axi_wvalid, 0);
        for (int i = 0; i < aw_stall; i++) begin
            check("wr_aw_stall_ready", s_axi_awready, 0);
            check("wr_aw_stall_valid", m_axi_awvalid, 1);
            check("wr_ar_blocked", s_axi_arready, 0);
            tick();
        end
        m_axi_awready = 1'b1;
        #1;
        check("wr_s_awready", s_axi_awready, onehot);
        tick();
        s_axi_awvalid[lane] = 1'b0;
        m_axi_awready = 1'b0;
        #1;
        check("wr_m_wvalid", m_axi_wvalid, 1);
        check("wr_m_wdata", m_axi_wdata, data);
        check("wr_m_awvalid_off", m_axi_awvalid, 0);
        check("wr_m_awaddr_off", m_axi_awaddr, 0);
        for (int i = 0; i < w_stall; i++) begin
            check("wr_w_stall_ready", s_axi_wready, 0);
            check("wr_w_stall_valid", m_axi_wvalid, 1);
            tick();
        end
        m_axi_wready = 1'b1;
        #1;
        check("wr_s_wready", s_axi_wready, onehot);
        tick();
        s_axi_wvalid[lane] = 1'b0;
        m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp = resp;
        s_axi_bready[lane] = 1'b1;
        #1;
        check("wr_s_bvalid", s_axi_bvalid, onehot);
        check("wr_s_bresp", s_axi_bresp[lane*2 +: 2], resp);
        check("wr_m_bready", m_axi_bready, 1);
        check("wr_b_ar_blocked", s_axi_arready, 0);
        check("wr_b_m_arvalid", m_axi_arvalid, 0);
        tick();
        m_axi_bvalid = 1'b0;
        s_axi_bready = '0;
        #1;
        check("wr_done_grant", grant, 0);
        check("wr_done_busy", busy, 0);
    endtask

    initial begin
        clear_inputs();

        // 1: reset values, then idle with no requests
        repeat (3) tick();
        check("reset_outs", all_vr, 0);
        aresetn = 1'b1;
        repeat (3) tick();
        check("idle_no_req", all_vr, 0);

        // 2: single read by req0, one-cycle arbitration
        s_axi_arvalid[0] = 1'b1;
        s_axi_araddr[31:0] = 32'h0000_1000;
        #1;
        check("arb_not_yet_valid", m_axi_arvalid, 0);
        check("arb_not_yet_busy", busy, 0);
        tick();
        read_txn(0, 32'h0000_1000, 32'hCAFE_BABE, 2'b00);

        // 3: simultaneous reads after reset alternate req0, req1, req0, req1
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        s_axi_arvalid = 2'b11;
        s_axi_araddr = {32'h0000_1200, 32'h0000_1100};
        tick();
        read_txn(0, 32'h0000_1100, 32'h1111_1111, 2'b00);
        tick();
        read_txn(1, 32'h0000_1200, 32'h2222_2222, 2'b11);
        s_axi_arvalid = 2'b11;
        s_axi_araddr = {32'h0000_1280, 32'h0000_1180};
        tick();
        read_txn(0, 32'h0000_1180, 32'h3131_3131, 2'b00);
        tick();
        read_txn(1, 32'h0000_1280, 32'h4242_4242, 2'b00);

        // 4: stalled write by req1 with SLVERR while req0 read waits
        s_axi_awvalid[1] = 1'b1;
        s_axi_awaddr[63:32] = 32'h0000_2004;
        s_axi_wvalid[1] = 1'b1;
        s_axi_wdata[63:32] = 32'h1234_5678;
        tick();
        s_axi_arvalid[0] = 1'b1;
        s_axi_araddr[31:0] = 32'h0000_3000;
        write_txn(1, 32'h0000_2004, 32'h1234_5678, 2'b10, 3, 2);
        tick();
        read_txn(0, 32'h0000_3000, 32'h3333_3333, 2'b00);

        // 5: req1 write+read with req0 read pending -> req1 W, req0 R, req1 R
        s_axi_awvalid[1] = 1'b1;
        s_axi_awaddr[63:32] = 32'h0000_4000;
        s_axi_wvalid[1] = 1'b1;
        s_axi_wdata[63:32] = 32'hA5A5_A5A5;
        s_axi_arvalid = 2'b11;
        s_axi_araddr = {32'h0000_5000, 32'h0000_6000};
        tick();
        write_txn(1, 32'h0000_4000, 32'hA5A5_A5A5, 2'b00, 0, 0);
        tick();
        read_txn(0, 32'h0000_6000, 32'h6666_6666, 2'b00);
        tick();
        read_txn(1, 32'h0000_5000, 32'h5555_5555, 2'b01);

        // 6: reset during RD_R clears outputs at once; req0 wins afterwards
        s_axi_arvalid[0] = 1'b1;
        s_axi_araddr[31:0] = 32'h0000_7000;
        tick();
        #1;
        check("rst_pre_grant", grant, 2'b01);
        m_axi_arready = 1'b1;
        tick();
        s_axi_arvalid = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1;
        s_axi_rready = 2'b01;
        #1;
        check("rst_pre_rvalid", s_axi_rvalid, 2'b01);
        aresetn = 1'b0;
        #1;
        check("rst_mid_outs", all_vr, 0);
        m_axi_rvalid = 1'b0;
        s_axi_rready = '0;
        s_axi_arvalid = 2'b11;
        s_axi_araddr = {32'h0000_8100, 32'h0000_8000};
        tick();
        tick();
        aresetn = 1'b1;
        #1;
        check("rst_release_idle", all_vr, 0);
        tick();
        read_txn(0, 32'h0000_8000, 32'h8888_8888, 2'b00);
        tick();
        read_txn(1, 32'h0000_8100, 32'h9999_9999, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
